// File: rtl/hilo_divider.sv
// HI/LO register unit: captures multu results, services MTHI/MTLO/MF* and
// runs a fixed-latency restoring DIV/DIVU producing one quotient bit per cycle.
module hilo_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    localparam logic [1:0]       OP_DIVU = 2'd0;
    localparam logic [1:0]       OP_DIV  = 2'd1;
    localparam logic [1:0]       OP_MTHI = 2'd2;
    localparam logic [1:0]       OP_MTLO = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             rem_ge;
    logic             is_signed;

    // Magnitudes for DIV; the most negative value maps onto itself, which the
    // unsigned iteration then treats as 2^(WIDTH-1).
    assign abs_a     = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    assign abs_b     = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    assign is_signed = (op == OP_DIV);

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, dvs_q};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        araw_d     = araw_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        zero_d     = zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (hilo_we) begin
                    hi_d = alu_hi;
                    lo_d = alu_lo;
                end
                if (start) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: begin
                            state_d    = ST_DIV;
                            cnt_d      = '0;
                            rem_d      = '0;
                            quo_d      = is_signed ? abs_a : a;
                            dvs_d      = is_signed ? abs_b : b;
                            qneg_d     = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_d     = is_signed & a[WIDTH-1];
                            araw_d     = a;
                            zero_d     = (b == '0);
                            div_zero_d = 1'b0;
                        end
                    endcase
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (rem_ge) begin
                    rem_d = rem_sub[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                // Divide-by-zero returns all-ones / original dividend, independent of sign.
                if (zero_q) begin
                    lo_d       = '1;
                    hi_d       = araw_q;
                    div_zero_d = 1'b1;
                end else begin
                    lo_d = qneg_q ? (WIDTH'(0) - quo_q) : quo_q;
                    hi_d = rneg_q ? (WIDTH'(0) - rem_q) : rem_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            araw_q     <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            araw_q     <= araw_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            zero_q     <= zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign rd_data  = rd_sel ? hi_q : lo_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed and randomized checks of hilo_divider against an arithmetic model
// of MIPS DIV/DIVU and the HI/LO write rules.
module tb_hilo_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hilo_we;
    logic [31:0] alu_lo, alu_hi;
    logic        rd_sel;
    logic [31:0] rd_data, hi, lo;
    logic        busy, done, div_zero;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    hilo_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hilo_we(hilo_we), .alu_lo(alu_lo), .alu_hi(alu_hi),
        .rd_sel(rd_sel), .rd_data(rd_data), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: MIPS semantics from plain integer division (truncating).
    task automatic model_div(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                             output logic [31:0] mlo, output logic [31:0] mhi);
        longint sa, sb, q, r;
        if (bv == 32'h0) begin
            mlo = 32'hFFFF_FFFF;
            mhi = av;
        end else if (o == 2'd0) begin
            mlo = av / bv;
            mhi = av % bv;
        end else begin
            sa  = longint'($signed(av));
            sb  = longint'($signed(bv));
            q   = sa / sb;
            r   = sa % sb;
            mlo = 32'(q);
            mhi = 32'(r);
        end
    endtask

    // Runs one division; optionally pokes start+hilo_we mid-flight.
    task automatic do_div(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input bit inject);
        logic [31:0] mlo, mhi;
        int cycles;
        int done_cnt;
        model_div(o, av, bv, mlo, mhi);
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        cycles   = 0;
        done_cnt = 0;
        while (busy === 1'b1 && cycles < 40) begin
            if (inject && cycles == 9) begin
                start = 1'b1; op = 2'd0; a = 32'd1; b = 32'd1;
                hilo_we = 1'b1; alu_hi = 32'hAAAA_AAAA; alu_lo = 32'hBBBB_BBBB;
            end
            tick();
            start = 1'b0; hilo_we = 1'b0;
            cycles++;
            if (done === 1'b1) done_cnt++;
            if (cycles == 16) begin
                check("hi_held_busy", hi, exp_hi);
                check("lo_held_busy", lo, exp_lo);
            end
        end
        check("latency", cycles, 32'd33);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("div_lo", lo, mlo);
        check("div_hi", hi, mhi);
        check("div_zero", {31'b0, div_zero}, {31'b0, (bv == 32'h0)});
        exp_lo = mlo;
        exp_hi = mhi;
        tick();
        if (done === 1'b1) done_cnt++;
        check("done_once", done_cnt, 32'd1);
        $display("div op=%0d a=%h b=%h -> lo=%h hi=%h dz=%0b cycles=%0d", o, av, bv, lo, hi, div_zero, cycles);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        hilo_we = 1'b0; alu_lo = '0; alu_hi = '0; rd_sel = 1'b0;
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dz", {31'b0, div_zero}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed divisions
        do_div(2'd0, 32'd100, 32'd7, 1'b0);
        check("divu_100_7_lo", lo, 32'd14);
        check("divu_100_7_hi", hi, 32'd2);
        do_div(2'd1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        do_div(2'd1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        check("div_7_m2_lo", lo, 32'hFFFF_FFFD);
        check("div_7_m2_hi", hi, 32'd1);
        do_div(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        do_div(2'd0, 32'h1234_5678, 32'h0, 1'b0);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_hi", hi, 32'h1234_5678);
        check("dz_flag", {31'b0, div_zero}, 32'd1);
        do_div(2'd0, 32'd9, 32'd3, 1'b0);
        check("dz_cleared", {31'b0, div_zero}, 32'd0);
        do_div(2'd1, 32'hFFFF_FFF0, 32'h0, 1'b0);

        // ALU capture and read mux
        hilo_we = 1'b1; alu_hi = 32'hDEAD_BEEF; alu_lo = 32'h00C0_FFEE;
        tick();
        hilo_we = 1'b0;
        rd_sel = 1'b1; #1;
        check("rd_hi", rd_data, 32'hDEAD_BEEF);
        rd_sel = 1'b0; #1;
        check("rd_lo", rd_data, 32'h00C0_FFEE);
        $display("hilo_we hi=%h lo=%h", hi, lo);
        hilo_we = 1'b1; alu_hi = 32'hDEAD_BEEF; alu_lo = 32'h1111_1111;
        start = 1'b1; op = 2'd3; a = 32'd5;
        tick();
        hilo_we = 1'b0; start = 1'b0;
        check("mtlo_wins_lo", lo, 32'd5);
        check("mtlo_alu_hi", hi, 32'hDEAD_BEEF);
        check("mt_no_busy", {31'b0, busy}, 32'd0);
        exp_hi = 32'hDEAD_BEEF; exp_lo = 32'd5;
        $display("mtlo+hilo_we hi=%h lo=%h", hi, lo);

        // Start and hilo_we ignored while busy
        do_div(2'd0, 32'd1000, 32'd33, 1'b1);

        // Reset mid-division
        start = 1'b1; op = 2'd2; a = 32'h55; tick();
        op = 2'd3; tick();
        start = 1'b0;
        check("pre_rst_hi", hi, 32'h55);
        check("pre_rst_lo", lo, 32'h55);
        start = 1'b1; op = 2'd0; a = 32'd100; b = 32'd7; tick();
        start = 1'b0;
        repeat (14) tick();
        rst = 1'b1; #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        tick();
        check("midrst_done", {31'b0, done}, 32'd0);
        #2 rst = 1'b0;
        tick();
        check("post_rst_done", {31'b0, done}, 32'd0);
        exp_hi = 32'h0; exp_lo = 32'h0;
        $display("reset mid-division hi=%h lo=%h busy=%0b", hi, lo, busy);
        do_div(2'd0, 32'd100, 32'd7, 1'b0);
        check("rerun_lo", lo, 32'd14);
        check("rerun_hi", hi, 32'd2);

        // Random divisions
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            logic [1:0]  ro;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = 32'h0 - 32'($urandom_range(1, 15));
                2: rb = (i % 8 == 0) ? 32'h0 : $urandom;
                default: rb = $urandom;
            endcase
            ro = 2'($urandom_range(0, 1));
            do_div(ro, ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
- Sequential HI/LO register unit for the mMIPS datapath; the receiving end of the ALU's {r2, r} result pair.
- Captures the ALU multu results.
- Executes iterative DIV/DIVU, one quotient bit per cycle.
- Services MTHI/MTLO writes and MFHI/MFLO reads; holds the pipeline off through a busy handshake.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe, sampled on a clk edge.
- op  in  2  command: 0 DIVU, 1 DIV, 2 MTHI, 3 MTLO.
- a  in  WIDTH  dividend, or MTHI/MTLO source data.
- b  in  WIDTH  divisor.
- hilo_we  in  1  capture the ALU multu result.
- alu_lo  in  WIDTH  ALU r (low product word).
- alu_hi  in  WIDTH  ALU r2 (high product word).
- rd_sel  in  1  read select: 0 LO, 1 HI.
- rd_data  out  WIDTH  combinational read of the selected register.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  division in progress; controller stalls MF*/MT*/multu/div.
- done  out  1  one-cycle pulse: division result written.
- div_zero  out  1  sticky flag: last division had b==0.

Behaviour:
- Reset (async, rst=1):
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - State IDLE, counter=0, internal quotient/remainder/divisor registers=0.
  - A division in flight is discarded and HI/LO are not written.
- States:
  - IDLE -> DIV on start with op in {0,1}.
  - DIV -> FIXUP after WIDTH iterations.
  - FIXUP -> IDLE.
- IDLE, start with op=2: hi<=a at that edge. With op=3: lo<=a. No busy, no done.
- IDLE, hilo_we=1: hi<=alu_hi, lo<=alu_lo at that edge.
  - If start op 2/3 is in the same cycle, the MT* write wins for its register; the other register takes the ALU value.
- IDLE, start op 0/1 (edge E0):
  - Latch |a| and |b| (DIV) or a and b (DIVU).
  - Latch sign_q = a[31]^b[31] and sign_r = a[31] (DIV only; 0 for DIVU).
  - Clear remainder; counter=0; busy=1 from E0.
  - A hilo_we in the same cycle is still applied.
- DIV:
  - Restoring shift-subtract, one bit per edge. rem = {rem, q_msb}; if rem >= divisor, subtract and set the q bit.
  - counter increments; after WIDTH edges (E1..E32) go to FIXUP.
- FIXUP (edge E33):
  - lo <= sign_q ? -q : q.
  - hi <= sign_r ? -rem : rem.
  - busy falls, done=1 for exactly one cycle following E33.
  - Total latency is 33 edges from start to result, fixed for all operands.
- Divide by zero (b==0 at E0):
  - Normal 33-cycle timing is kept.
  - FIXUP writes lo=0xFFFFFFFF and hi=a (the original a, unsigned and signed alike).
  - div_zero<=1 at E33.
  - div_zero is cleared by the next division start (E0) or by reset.
- Signed overflow: 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0. This falls out of the magnitude arithmetic; no special case.
- While busy:
  - start is ignored (no restart, no MT* write).
  - hilo_we is ignored (write dropped).
  - rd_data, hi and lo show the pre-division values until E33.
- Arithmetic: all quotient/remainder math is unsigned WIDTH-bit, plus a WIDTH+1-bit compare/subtract. Negation is two's complement modulo 2^WIDTH.
- rd_data = rd_sel ? hi : lo, purely combinational, so a write is visible the cycle after its edge.

Test Plan:
- DIVU a=100, b=7 -> busy high for 33 cycles, done pulse after E33, lo=14, hi=2, div_zero=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1; next DIVU 9/3 clears div_zero and gives lo=3, hi=0.
- hilo_we with alu_hi=0xDEADBEEF, alu_lo=0x00C0FFEE -> rd_sel=1 reads 0xDEADBEEF, rd_sel=0 reads 0x00C0FFEE. Same cycle with MTLO a=5 -> lo=5, hi=0xDEADBEEF.
- During a division, pulse start (DIVU 1/1) and hilo_we at cycle 10 -> both ignored; the final result is the original division's and done pulses exactly once.
- Assert rst at cycle 15 of DIVU 100/7 with hi=lo=0x55 beforehand -> hi=lo=0, busy=0, no done pulse. A fresh DIVU 100/7 then completes normally with lo=14, hi=2.
